// File: rtl/ahb_round_robin_arbiter.sv
// Round-robin arbiter for a shared AHB-Lite subordinate bus.
// Issues a registered one-hot grant plus address- and data-phase owner
// indices. Supports a per-owner beat limit, locked sequences (HMASTLOCK)
// and parking on a default manager when nobody is requesting.
module ahb_round_robin_arbiter #(
  parameter int NumManagers = 3,
  parameter int MaxBeats    = 4,
  parameter int DefaultMgr  = 0,
  parameter int OwnerW      = $clog2(NumManagers)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NumManagers-1:0] req,
  input  logic [NumManagers-1:0] lock,
  input  logic [1:0]             trans,
  input  logic                   readyOut,
  output logic [NumManagers-1:0] grant,
  output logic [OwnerW-1:0]      addrOwner,
  output logic [OwnerW-1:0]      dataOwner,
  output logic                   mastLock
);

  // Counter only has to reach MaxBeats-1 before it clears on limitHit.
  localparam int CntW = (MaxBeats > 1) ? $clog2(MaxBeats) : 1;

  localparam logic [1:0] TransIdle = 2'b00;
  localparam logic [1:0] TransBusy = 2'b01;

  typedef enum logic {
    OPEN = 1'b0,
    HELD = 1'b1
  } state_t;

  state_t                   state;
  logic [CntW-1:0]          beatCnt;

  logic                     beat;
  logic                     limitHit;
  logic                     ownerReq;
  logic                     ownerLock;
  logic                     lockOk;
  logic                     rearb;
  logic                     handover;
  logic                     nextLock;
  logic [NumManagers-1:0]   reqRot;
  logic [OwnerW:0]          rotShift;
  logic [OwnerW:0]          sum;
  logic [OwnerW-1:0]        winner;
  logic [OwnerW-1:0]        nextOwner;

  // Decide whether the current owner may be replaced at this edge.
  always_comb begin
    beat      = readyOut & trans[1];
    limitHit  = (MaxBeats != 0) && beat && (beatCnt == CntW'(MaxBeats - 1));
    ownerReq  = req[addrOwner];
    ownerLock = lock[addrOwner];
    // A locked owner only yields once it drops lock or req on an accepted edge.
    lockOk    = (state == OPEN) | ~ownerLock | ~ownerReq;
    rearb     = readyOut & lockOk & (trans != TransBusy) &
                (~ownerReq | (trans == TransIdle) | limitHit);
  end

  // Round-robin search starting just above the current owner, owner itself last.
  always_comb begin
    rotShift = {1'b0, addrOwner} + 1'b1;
    // reqRot[i] is the request of manager (addrOwner + 1 + i) mod NumManagers.
    reqRot   = NumManagers'({req, req} >> rotShift);
    winner   = OwnerW'(DefaultMgr);
    sum      = '0;
    // Walk downward so the lowest rotated position (closest to owner+1) wins.
    for (int i = NumManagers - 1; i >= 0; i--) begin
      if (reqRot[i]) begin
        sum = {1'b0, addrOwner} + (OwnerW + 1)'(i + 1);
        if (sum >= (OwnerW + 1)'(NumManagers)) begin
          sum = sum - (OwnerW + 1)'(NumManagers);
        end
        winner = sum[OwnerW-1:0];
      end
    end
    nextOwner = rearb ? winner : addrOwner;
    handover  = rearb & (winner != addrOwner);
    nextLock  = lock[nextOwner] & req[nextOwner];
  end

  // Ownership, lock FSM and beat counter; everything holds while readyOut is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant     <= NumManagers'(1) << DefaultMgr;
      addrOwner <= OwnerW'(DefaultMgr);
      dataOwner <= OwnerW'(DefaultMgr);
      mastLock  <= 1'b0;
      state     <= OPEN;
      beatCnt   <= '0;
    end else if (readyOut) begin
      dataOwner <= addrOwner;
      addrOwner <= nextOwner;
      grant     <= NumManagers'(1) << nextOwner;
      mastLock  <= nextLock;
      state     <= nextLock ? HELD : OPEN;
      if (handover || limitHit) begin
        beatCnt <= '0;
      end else if (beat) begin
        beatCnt <= beatCnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ahb_round_robin_arbiter.sv
// Self-checking bench for ahb_round_robin_arbiter: directed scenarios
// followed by randomized traffic, all compared against a behavioural model.
module tb_ahb_round_robin_arbiter;

  localparam int N  = 3;
  localparam int MB = 4;
  localparam int DM = 0;
  localparam int OW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [N-1:0]  lock;
  logic [1:0]    trans;
  logic          readyOut;
  logic [N-1:0]  grant;
  logic [OW-1:0] addrOwner;
  logic [OW-1:0] dataOwner;
  logic          mastLock;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  int m_owner;
  int m_downer;
  int m_cnt;
  int m_held;

  always #5 clk = ~clk;

  ahb_round_robin_arbiter #(
    .NumManagers(N),
    .MaxBeats(MB),
    .DefaultMgr(DM),
    .OwnerW(OW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .lock(lock),
    .trans(trans),
    .readyOut(readyOut),
    .grant(grant),
    .addrOwner(addrOwner),
    .dataOwner(dataOwner),
    .mastLock(mastLock)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply the arbitration rules to the inputs present at the last clock edge.
  task automatic model_edge();
    bit own_req, own_lock, is_beat, lim, may_move;
    int nxt;
    if (reset) begin
      m_owner = DM; m_downer = DM; m_cnt = 0; m_held = 0;
      return;
    end
    if (!readyOut) return;
    is_beat  = (trans == 2'd2) || (trans == 2'd3);
    lim      = (MB != 0) && is_beat && (m_cnt == MB - 1);
    own_req  = req[m_owner];
    own_lock = lock[m_owner];
    may_move = (m_held == 0 || !own_lock || !own_req) && (trans != 2'd1) &&
               (!own_req || trans == 2'd0 || lim);
    nxt = m_owner;
    if (may_move) begin
      nxt = DM;
      for (int k = 1; k <= N; k++) begin
        if (req[(m_owner + k) % N]) begin
          nxt = (m_owner + k) % N;
          break;
        end
      end
    end
    if (nxt != m_owner || lim) m_cnt = 0;
    else if (is_beat) m_cnt = m_cnt + 1;
    m_downer = m_owner;
    m_owner  = nxt;
    m_held   = (lock[nxt] && req[nxt]) ? 1 : 0;
  endtask

  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lk,
                      input logic [1:0] tr, input logic rdy);
    reset = r; req = rq; lock = lk; trans = tr; readyOut = rdy;
    @(posedge clk);
    model_edge();
    #1;
    chk("grant", 32'(grant), 32'(1 << m_owner));
    chk("addrOwner", 32'(addrOwner), 32'(m_owner));
    chk("dataOwner", 32'(dataOwner), 32'(m_downer));
    chk("mastLock", 32'(mastLock), 32'(m_held));
  endtask

  initial begin
    logic          r_r, r_rdy;
    logic [N-1:0]  r_req, r_lk;
    logic [1:0]    r_tr;
    logic [1:0]    lk_trans [8];

    reset = 1'b1; req = '0; lock = '0; trans = 2'b00; readyOut = 1'b1;
    m_owner = DM; m_downer = DM; m_cnt = 0; m_held = 0;

    // Reset and idle parking
    step(1'b1, 3'b000, 3'b000, 2'b00, 1'b1);
    chk("rst_grant", 32'(grant), 32'h1);
    chk("rst_mastLock", 32'(mastLock), 32'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 3'b000, 3'b000, 2'b00, 1'b1);
    chk("idle_grant", 32'(grant), 32'h1);

    // Round robin with everyone requesting and the owner idle
    step(1'b0, 3'b111, 3'b000, 2'b00, 1'b1);
    chk("rr_grant1", 32'(grant), 32'h2);
    chk("rr_data1", 32'(dataOwner), 32'h0);
    step(1'b0, 3'b111, 3'b000, 2'b00, 1'b1);
    chk("rr_grant2", 32'(grant), 32'h4);
    step(1'b0, 3'b111, 3'b000, 2'b00, 1'b1);
    chk("rr_grant3", 32'(grant), 32'h1);
    chk("rr_data3", 32'(dataOwner), 32'h2);

    // Beat limit: mgr0 bursts, loses the bus at the 4th accepted beat
    step(1'b0, 3'b011, 3'b000, 2'b10, 1'b1);
    step(1'b0, 3'b011, 3'b000, 2'b11, 1'b1);
    step(1'b0, 3'b011, 3'b000, 2'b11, 1'b1);
    chk("bl_hold", 32'(grant), 32'h1);
    step(1'b0, 3'b011, 3'b000, 2'b11, 1'b1);
    chk("bl_handover", 32'(grant), 32'h2);
    step(1'b0, 3'b011, 3'b000, 2'b10, 1'b1);
    step(1'b0, 3'b001, 3'b000, 2'b00, 1'b1);
    chk("bl_back", 32'(grant), 32'h1);

    // Wait states freeze everything, including the beat counter
    step(1'b0, 3'b011, 3'b000, 2'b10, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'b011, 3'b000, 2'b11, 1'b0);
      chk("ws_frozen", 32'(grant), 32'h1);
    end
    step(1'b0, 3'b011, 3'b000, 2'b11, 1'b1);
    step(1'b0, 3'b011, 3'b000, 2'b11, 1'b1);
    chk("ws_no_early", 32'(grant), 32'h1);
    step(1'b0, 3'b011, 3'b000, 2'b11, 1'b1);
    chk("ws_limit", 32'(grant), 32'h2);

    // Locked sequence by mgr2 with BUSY cycles
    step(1'b0, 3'b100, 3'b100, 2'b00, 1'b1);
    chk("lk_grant", 32'(grant), 32'h4);
    chk("lk_mastLock", 32'(mastLock), 32'h1);
    lk_trans = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b11, 2'b11, 2'b01, 2'b11};
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 3'b111, 3'b100, lk_trans[i], 1'b1);
      chk("lk_held", 32'(grant), 32'h4);
    end
    step(1'b0, 3'b111, 3'b000, 2'b01, 1'b1);
    chk("lk_busy_keep", 32'(grant), 32'h4);
    chk("lk_unlock", 32'(mastLock), 32'h0);
    step(1'b0, 3'b111, 3'b000, 2'b11, 1'b1);
    step(1'b0, 3'b111, 3'b000, 2'b00, 1'b1);
    chk("lk_release", 32'(grant), 32'h1);

    // Reset in the middle of mgr1's burst during a wait state
    step(1'b0, 3'b010, 3'b000, 2'b00, 1'b1);
    chk("mb_owner1", 32'(grant), 32'h2);
    step(1'b0, 3'b010, 3'b000, 2'b10, 1'b1);
    step(1'b0, 3'b010, 3'b000, 2'b11, 1'b1);
    step(1'b1, 3'b010, 3'b010, 2'b11, 1'b0);
    chk("mb_rst_grant", 32'(grant), 32'h1);
    chk("mb_rst_lock", 32'(mastLock), 32'h0);
    // Counter must have restarted: handover exactly at the 4th beat
    step(1'b0, 3'b011, 3'b000, 2'b10, 1'b1);
    step(1'b0, 3'b011, 3'b000, 2'b11, 1'b1);
    step(1'b0, 3'b011, 3'b000, 2'b11, 1'b1);
    chk("mb_cnt_hold", 32'(grant), 32'h1);
    step(1'b0, 3'b011, 3'b000, 2'b11, 1'b1);
    chk("mb_cnt_limit", 32'(grant), 32'h2);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      r_r   = ($urandom_range(0, 59) == 0);
      r_req = 3'($urandom_range(0, 7));
      r_lk  = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      r_tr  = 2'($urandom_range(0, 3));
      r_rdy = ($urandom_range(0, 4) != 0);
      step(r_r, r_req, r_lk, r_tr, r_rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_round_robin_arbiter.md
Name: ahb_round_robin_arbiter

Overview:
- Shares one AHB-Lite subordinate bus (addr/control/trans/write/wData muxed upstream) among NumManagers managers.
- Issues a one-hot grant and registered address-phase and data-phase owner indices; the fabric uses these to steer muxes and route rData/resp/readyOut.
- Uses round-robin fairness, a per-owner beat limit, locked-transfer support and default-manager parking.
- Sits between the manager ports and the AHBCommon_if-based subordinate, e.g. SubDummy.

Parameters:
- NumManagers, 3, number of requesting managers (2..8).
- MaxBeats, 4, accepted NONSEQ/SEQ beats an owner may issue while others wait; 0 disables the limit.
- DefaultMgr, 0, manager parked on when no requests are pending.
- OwnerW, $clog2(NumManagers), width of the owner indices.

Ports:
- clk  input  1  bus clock; every flop is rising-edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NumManagers  per-manager bus request.
- lock  input  NumManagers  per-manager locked-sequence request.
- trans  input  2  HTRANS of the current address-phase owner: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- readyOut  input  1  HREADY from the subordinate; a transfer is accepted on any edge where this is 1.
- grant  output  NumManagers  one-hot grant, registered.
- addrOwner  output  OwnerW  index of the manager driving the address phase.
- dataOwner  output  OwnerW  index of the manager owning the current data phase.
- mastLock  output  1  HMASTLOCK for the current address phase, registered.

Behaviour:
- Reset: applied at a clock edge while reset=1, and it overrides everything, including mid-burst or mid-wait-state.
  - grant = one-hot DefaultMgr; addrOwner = dataOwner = DefaultMgr.
  - mastLock = 0; beat counter = 0.
- Internal state: two-state FSM, OPEN and HELD.
  - HELD is entered when lock[addrOwner] & req[addrOwner] is registered at an accept edge; mastLock reflects HELD.
  - HELD returns to OPEN at the first accept edge where lock[addrOwner] = 0 or req[addrOwner] = 0.
- Nothing changes on edges where readyOut = 0: grant, owners, counter and FSM all hold, which covers wait states.
- dataOwner <= addrOwner on every edge with readyOut = 1, so it lags addrOwner by exactly one accepted cycle.
- Beat counter:
  - Increments on readyOut=1 & trans ∈ {NONSEQ, SEQ}.
  - limitHit = (MaxBeats != 0) & (counter == MaxBeats-1) & that increment condition.
  - Clears on handover and on limitHit.
- Re-arbitration is allowed at an edge only when all hold: readyOut = 1, FSM in OPEN (or leaving HELD this edge), and trans != BUSY.
  - In addition, one of the following must hold: req[addrOwner] = 0, trans == IDLE, or limitHit.
- Winner selection is round-robin: search req from addrOwner+1 upward, wrapping modulo NumManagers, with addrOwner itself checked last.
  - No request set -> DefaultMgr.
  - Winner == addrOwner -> no change, and the counter still clears if limitHit.
  - Winner != addrOwner -> grant, addrOwner and the FSM update at this edge; the new owner drives the address phase from the next cycle.
- mastLock <= lock[next addrOwner] & req[next addrOwner] at each accept edge.
- Invariants: grant is always one-hot and equals 1<<addrOwner. Requests from managers >= NumManagers cannot exist.
- Simultaneous events:
  - A lock deassertion and limitHit on the same edge permit handover on that edge.
  - Assertion of reset wins over any other event.

Test Plan:
- Reset with req=000, then idle for 5 cycles -> grant=001, addrOwner=0, dataOwner=0, mastLock=0 throughout.
- Round-robin: req=111 with trans=IDLE and readyOut=1 for 3 edges -> grant sequence 010, 100, 001; dataOwner follows addrOwner one edge later.
- Beat limit, MaxBeats=4: mgr0 bursts NONSEQ,SEQ,SEQ,SEQ,SEQ with req=011 -> handover to mgr1 at the 4th accepted beat; mgr0 gets the bus back after mgr1 drops req.
- Wait states: readyOut=0 for 3 cycles during a beat with req=011 -> grant, owners and counter frozen; arbitration resumes on the first readyOut=1 edge.
- Lock and BUSY: mgr2 with lock=100 and req=111 issues 8 beats including BUSY -> grant stays 100 and mastLock=1; release happens at the first accept edge after lock drops, never on a BUSY cycle.
- Reset mid-burst: assert reset during mgr1's 2nd SEQ while readyOut=0 -> next edge gives grant=001, counter=0, mastLock=0.
